// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master with quarter-period bit timing
module i2c_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wr_data,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SCL_oe,
  output logic       SDA_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP} state_t;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  state_t     state, state_d;
  logic [9:0] cnt, cnt_d;
  logic [1:0] qtr, qtr_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] shreg, shreg_d, data_reg, data_reg_d, rd_data_d;
  logic       rw_reg, rw_reg_d, tx_bit, tx_bit_d;
  logic       busy_d, done_d, ack_err_d, scl_oe_d, sda_oe_d;
  logic       hold, tick;

  always_comb begin
    // A responder holding SCL low during the high phase freezes the quarter
    hold       = (qtr == 2'd2) && !SCL_in;
    tick       = (state != IDLE) && !hold && (cnt == DIV_LAST);
    state_d    = state;
    qtr_d      = qtr;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    data_reg_d = data_reg;
    rd_data_d  = rd_data;
    rw_reg_d   = rw_reg;
    tx_bit_d   = tx_bit;
    busy_d     = busy;
    done_d     = 1'b0;
    ack_err_d  = ack_err;

    if (state == IDLE)  cnt_d = '0;
    else if (hold)      cnt_d = cnt;
    else if (tick)      cnt_d = '0;
    else                cnt_d = cnt + 10'd1;

    case (state)
      IDLE: begin
        // done-cycle requests are dropped so back-to-back starts need a true idle cycle
        if (start && !done) begin
          shreg_d    = {addr, rw};
          data_reg_d = wr_data;
          rw_reg_d   = rw;
          state_d    = START;
          qtr_d      = 2'd0;
          busy_d     = 1'b1;
          ack_err_d  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (qtr == 2'd0) begin
            qtr_d = 2'd1;
          end else begin
            state_d   = ADDR;
            qtr_d     = 2'd0;
            bit_cnt_d = 3'd0;
            tx_bit_d  = ~shreg[7];
          end
        end
      end
      ADDR, AACK, DATA, DACK: begin
        if (tick) begin
          if (qtr == 2'd2) begin
            if (state == AACK && SDA_in) ack_err_d = 1'b1;
            if (state == DACK && !rw_reg && SDA_in) ack_err_d = 1'b1;
            if (state == DATA && rw_reg) rd_data_d = {rd_data[6:0], SDA_in};
          end
          if (qtr != 2'd3) begin
            qtr_d = qtr + 2'd1;
          end else begin
            qtr_d     = 2'd0;
            bit_cnt_d = bit_cnt + 3'd1;
            case (state)
              ADDR: begin
                shreg_d = {shreg[6:0], 1'b0};
                if (bit_cnt == 3'd7) begin
                  state_d  = AACK;
                  tx_bit_d = 1'b0;
                end else begin
                  tx_bit_d = ~shreg[6];
                end
              end
              AACK: begin
                bit_cnt_d = 3'd0;
                if (ack_err) begin
                  state_d = STOP;
                end else begin
                  state_d  = DATA;
                  shreg_d  = data_reg;
                  tx_bit_d = !rw_reg && !data_reg[7];
                end
              end
              DATA: begin
                shreg_d = {shreg[6:0], 1'b0};
                if (bit_cnt == 3'd7) begin
                  state_d  = DACK;
                  tx_bit_d = 1'b0;
                end else begin
                  tx_bit_d = !rw_reg && !shreg[6];
                end
              end
              default: state_d = STOP;
            endcase
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (qtr == 2'd3) begin
            state_d = IDLE;
            qtr_d   = 2'd0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            qtr_d = qtr + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pad drives are decoded from the next state so they leave flops glitch-free
    case (state_d)
      START: begin
        scl_oe_d = (qtr_d == 2'd1);
        sda_oe_d = 1'b1;
      end
      ADDR, AACK, DATA, DACK: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = tx_bit_d;
      end
      STOP: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = (qtr_d != 2'd3);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      qtr      <= 2'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      data_reg <= 8'h00;
      rd_data  <= 8'h00;
      rw_reg   <= 1'b0;
      tx_bit   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      SCL_oe   <= 1'b0;
      SDA_oe   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      qtr      <= qtr_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      data_reg <= data_reg_d;
      rd_data  <= rd_data_d;
      rw_reg   <= rw_reg_d;
      tx_bit   <= tx_bit_d;
      busy     <= busy_d;
      done     <= done_d;
      ack_err  <= ack_err_d;
      SCL_oe   <= scl_oe_d;
      SDA_oe   <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - bench for i2c_master with a bus-decoding responder and scoreboard
module tb_i2c_master;

  logic       clk_50M = 1'b0;
  logic       rst_n, start, rw;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic       SCL_in, SDA_in, SCL_oe, SDA_oe, busy, done, ack_err;
  logic [7:0] rd_data;

  always #10 clk_50M = ~clk_50M;

  i2c_master #(.CLK_DIV(4)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr),
    .wr_data(wr_data), .SCL_in(SCL_in), .SDA_in(SDA_in), .SCL_oe(SCL_oe),
    .SDA_oe(SDA_oe), .busy(busy), .done(done), .ack_err(ack_err), .rd_data(rd_data)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Responder: decodes the wired bus, ACKs its address, supplies read data, can stretch SCL
  logic [6:0] resp_addr = 7'h50;
  logic [7:0] resp_byte = 8'h00;
  logic       nak_data = 1'b0, stretch_en = 1'b0;
  logic       scl_prev = 1'b1, sda_prev = 1'b1, oe_prev = 1'b0;
  logic       active = 1'b0, drive = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
  logic [7:0] addr_seen = 8'h00, data_seen = 8'h00;
  int         nrise = 0, fall_cnt = 0, stretch_left = 0;
  logic       trig, scl_bus, sda_bus;

  assign trig    = stretch_en && !SCL_oe && oe_prev && (fall_cnt == 2);
  assign scl_bus = !SCL_oe && !trig && (stretch_left == 0);
  assign sda_bus = !SDA_oe && !drive;
  assign SCL_in  = scl_bus;
  assign SDA_in  = sda_bus;

  function automatic logic slave_drive(input int b);
    logic m;
    m = (addr_seen[7:1] == resp_addr);
    if (b == 8) return m;
    if (b >= 9 && b <= 16) return m && addr_seen[0] && !resp_byte[16-b];
    if (b == 17) return m && !addr_seen[0] && !nak_data;
    return 1'b0;
  endfunction

  always @(negedge clk_50M) begin
    scl_prev <= scl_bus;
    sda_prev <= sda_bus;
    oe_prev  <= SCL_oe;
    if (trig) stretch_left <= 37;
    else if (stretch_left != 0) stretch_left <= stretch_left - 1;
    if (oe_prev && !SCL_oe) fall_cnt <= fall_cnt + 1;
    if (scl_prev && scl_bus && sda_prev && !sda_bus) begin
      active <= 1'b1; nrise <= 0; addr_seen <= 8'h00; data_seen <= 8'h00;
      ack1 <= 1'b0; ack2 <= 1'b0; fall_cnt <= 0; drive <= 1'b0;
    end else if (scl_prev && scl_bus && !sda_prev && sda_bus) begin
      active <= 1'b0; drive <= 1'b0;
    end else if (active && !scl_prev && scl_bus) begin
      nrise <= nrise + 1;
      if (nrise < 8) addr_seen <= {addr_seen[6:0], sda_bus};
      else if (nrise == 8) ack1 <= sda_bus;
      else if (nrise < 17) data_seen <= {data_seen[6:0], sda_bus};
      else if (nrise == 17) ack2 <= sda_bus;
    end else if (active && scl_prev && !scl_bus) begin
      drive <= slave_drive(nrise);
    end
  end

  typedef struct {
    logic       ack;
    logic [7:0] rd;
    int         cyc;
    logic [7:0] abyte;
    logic [7:0] dbyte;
    logic       ack1;
    logic       ack2;
  } exp_t;

  exp_t sb[$];
  logic busy_prev = 1'b0, done_prev = 1'b0;
  int   cyc = 0, done_cnt = 0;

  always @(negedge clk_50M) begin
    exp_t e;
    busy_prev <= busy;
    done_prev <= done;
    if (busy && !busy_prev) cyc <= 1;
    else cyc <= cyc + 1;
    if (done_prev) check("done_width", done, 1'b0);
    if (done) begin
      done_cnt <= done_cnt + 1;
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ack_err", ack_err, e.ack);
        check("rd_data", rd_data, e.rd);
        check("cycles", cyc, e.cyc);
        check("bus_addr_byte", addr_seen, e.abyte);
        check("bus_data_byte", data_seen, e.dbyte);
        check("bus_addr_ack", ack1, e.ack1);
        check("bus_data_ack", ack2, e.ack2);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wr;
    logic [6:0] raddr;
    logic [7:0] rbyte;
    logic       nak;
    logic       stretch;
    logic       exp_ack;
    logic [7:0] exp_rd;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic launch(input logic r, input logic [6:0] a, input logic [7:0] w,
                        input logic ea, input logic [7:0] erd, input int ecyc);
    exp_t e;
    logic m;
    m       = (a == resp_addr);
    e.ack   = ea;
    e.rd    = erd;
    e.cyc   = ecyc;
    e.abyte = {a, r};
    e.dbyte = m ? (r ? resp_byte : w) : 8'h00;
    e.ack1  = !m;
    e.ack2  = m ? (r ? 1'b1 : nak_data) : 1'b0;
    sb.push_back(e);
    rw = r; addr = a; wr_data = w; start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    check("accept_busy", busy, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    int c0;
    n  = 0;
    c0 = done_cnt;
    while (done_cnt == c0 && n < 2000) begin
      @(negedge clk_50M);
      n++;
    end
    check("done_seen", done_cnt - c0, 1);
    repeat (4) @(negedge clk_50M);
  endtask

  initial begin
    int n;
    logic busy_seen;
    vecs[0] = '{1'b0, 7'h50, 8'h5A, 7'h50, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 312};
    vecs[1] = '{1'b0, 7'h21, 8'h77, 7'h50, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 168};
    vecs[2] = '{1'b1, 7'h50, 8'h00, 7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 312};
    vecs[3] = '{1'b0, 7'h50, 8'h33, 7'h50, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 349};
    vecs[4] = '{1'b0, 7'h12, 8'hC3, 7'h12, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 312};
    vecs[5] = '{1'b1, 7'h7F, 8'h00, 7'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 312};
    vecs[6] = '{1'b1, 7'h50, 8'h00, 7'h50, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 349};
    vecs[7] = '{1'b1, 7'h21, 8'h00, 7'h50, 8'h99, 1'b0, 1'b0, 1'b1, 8'h3C, 168};

    rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 7'h00; wr_data = 8'h00;
    repeat (3) @(negedge clk_50M);
    check("rst_scl_oe", SCL_oe, 1'b0);
    check("rst_sda_oe", SDA_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    for (int i = 0; i < 8; i++) begin
      resp_addr = vecs[i].raddr; resp_byte = vecs[i].rbyte;
      nak_data = vecs[i].nak; stretch_en = vecs[i].stretch;
      @(negedge clk_50M);
      launch(vecs[i].rw, vecs[i].addr, vecs[i].wr, vecs[i].exp_ack, vecs[i].exp_rd, vecs[i].exp_cyc);
      wait_done();
    end

    // start pulses mid-ADDR and in the done cycle must both be ignored
    resp_addr = 7'h50; nak_data = 1'b0; stretch_en = 1'b0;
    @(negedge clk_50M);
    launch(1'b0, 7'h50, 8'h5A, 1'b0, vecs[7].exp_rd, 312);
    repeat (20) @(negedge clk_50M);
    addr = 7'h33; wr_data = 8'hFF; rw = 1'b1; start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk_50M);
      n++;
    end
    check("done_reached", done, 1'b1);
    addr = 7'h44; rw = 1'b0; start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk_50M);
      busy_seen = busy_seen | busy;
    end
    check("done_cycle_start_ignored", busy_seen, 1'b0);
    check("no_extra_expect", sb.size(), 0);

    // asynchronous reset during DATA bit 4, then an immediate new write
    @(negedge clk_50M);
    launch(1'b0, 7'h50, 8'hC3, 1'b0, 8'h00, 312);
    n = 0;
    while (nrise != 13 && n < 2000) begin
      @(negedge clk_50M);
      n++;
    end
    while (!SCL_oe && n < 2000) begin
      @(negedge clk_50M);
      n++;
    end
    check("reached_data_bit4", nrise, 13);
    check("pre_reset_sda_oe", SDA_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_scl_oe", SCL_oe, 1'b0);
    check("mid_rst_sda_oe", SDA_oe, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rd_data", rd_data, 8'h00);
    check("mid_rst_done", done, 1'b0);
    sb.delete();
    @(negedge clk_50M);
    rst_n = 1'b1;
    launch(1'b0, 7'h50, 8'h96, 1'b0, 8'h00, 312);
    wait_done();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
